vec_wb_assembler: RTL
=====================

VEC_WB_ASSEMBLER -- requirements
Module: vec_wb_assembler

Interface
REQ-001 Parameter vlen_p, default 8: number of elements per vector.
REQ-002 Parameter vdw_p, default 32: bits per element.
REQ-003 Parameter els_p, default 32: total vectors in the downstream register file.
REQ-004 Parameter lanes_p, default 4: register-file lanes; localparam addr_width_lp = BSG_SAFE_CLOG2(els_p/lanes_p); localparam cnt_width_lp = BSG_SAFE_CLOG2(vlen_p).
REQ-005 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset_i  input  1  asynchronous, active-high reset.
REQ-007 cmd_v_i  input  1  writeback command valid.
REQ-008 cmd_addr_i  input  addr_width_lp  lane-local destination vector address.
REQ-009 cmd_ready_o  output  1  command accepted when cmd_v_i & cmd_ready_o.
REQ-010 elem_v_i  input  1  result element valid.
REQ-011 elem_data_i  input  vdw_p  result element.
REQ-012 elem_ready_o  output  1  element accepted when elem_v_i & elem_ready_o.
REQ-013 w_en_o  output  1  one-cycle write strobe to one register-file lane's write port.
REQ-014 w_addr_o  output  addr_width_lp  write address, valid when w_en_o=1.
REQ-015 w_data_o  output  vlen_p*vdw_p  assembled vector, element k at bits [k*vdw_p +: vdw_p], valid when w_en_o=1.
REQ-016 busy_o  output  1  high whenever state is not IDLE.

Function
REQ-017 The block SHALL implement states IDLE, COLLECT, WRITE.
REQ-018 cmd_ready_o SHALL be 1 in IDLE and WRITE, 0 in COLLECT.
REQ-019 elem_ready_o SHALL be 1 only in COLLECT.
REQ-020 Command handshake in IDLE or WRITE SHALL latch cmd_addr_i, clear the element counter to 0, and move to COLLECT next cycle.
REQ-021 Each element handshake in COLLECT SHALL store elem_data_i at element index = counter, then increment the counter.
REQ-022 The handshake occurring at counter = vlen_p-1 SHALL move to WRITE next cycle; counter returns to 0; no counter wrap beyond vlen_p-1.
REQ-023 In WRITE, w_en_o SHALL be 1 for exactly that one cycle, with w_addr_o = latched address and w_data_o = all vlen_p collected elements.
REQ-024 Latency: w_en_o SHALL assert the cycle after the last element handshake.
REQ-025 From WRITE, the next state SHALL be COLLECT if a command handshakes that cycle, else IDLE (back-to-back vectors with no idle bubble).
REQ-026 w_en_o SHALL be 0 in IDLE and COLLECT; w_addr_o/w_data_o otherwise reflect internal registers and are don't-care.
REQ-027 elem_v_i outside COLLECT and cmd_v_i in COLLECT SHALL be ignored with no state change.
REQ-028 Element data SHALL be stored unmodified; no width conversion or arithmetic.
REQ-029 elem_v_i with stalled (low) cycles in COLLECT SHALL leave counter and buffer unchanged.
REQ-030 Element buffer is overwritten fully per vector; no clear between vectors is required.

Reset
REQ-031 reset_i=1 SHALL immediately force state IDLE, counter 0, latched address 0, element buffer 0, w_en_o 0, busy_o 0, cmd_ready_o 1, elem_ready_o 0.
REQ-032 Reset during COLLECT or WRITE SHALL discard the partial vector; no write strobe after reset deasserts until a new full vector is collected.

Verification
REQ-033 Reset, then cmd addr=5, elements 0x10..0x17 one per cycle -> single w_en_o pulse, w_addr_o=5, w_data_o element k = 0x10+k, cycle after last element.
REQ-034 Elements with random elem_v_i gaps -> same result as REQ-033; no strobe before the 8th handshake.
REQ-035 cmd addr=2 held valid during WRITE of vector addr=5 -> strobe for 5, next cycle in COLLECT, next strobe addr=2, no idle cycle.
REQ-036 elem_v_i=1 in IDLE and cmd_v_i=1 in COLLECT with addr=7 -> no effect; collected vector written to original address.
REQ-037 Assert reset_i after 4 of 8 elements -> outputs return to reset values within the cycle; no w_en_o; new command then completes normally.
REQ-038 lanes_p=4, els_p=32 -> addr width 3; cmd addr=7 written as w_addr_o=7.

Source files
------------

// File: rtl/vec_wb_assembler_if.sv
// rtl/vec_wb_assembler_if.sv - command, element and register-file write bundle for the assembler
//
// Groups the three channels of vec_wb_assembler:
//   cmd_v_i / cmd_addr_i / cmd_ready_o       writeback command (lane-local vector address)
//   elem_v_i / elem_data_i / elem_ready_o    result element stream
//   w_en_o / w_addr_o / w_data_o             one-cycle write to a register-file lane
//   busy_o                                   assembler not idle
// Modport slave is the assembler's view; modport master is the producer/consumer side.

interface vec_wb_assembler_if #(
    parameter int vlen_p  = 8,
    parameter int vdw_p   = 32,
    parameter int els_p   = 32,
    parameter int lanes_p = 4
);
    localparam int addr_width_lp = ((els_p / lanes_p) <= 1) ? 1 : $clog2(els_p / lanes_p);

    logic                      cmd_v_i;
    logic [addr_width_lp-1:0]  cmd_addr_i;
    logic                      cmd_ready_o;

    logic                      elem_v_i;
    logic [vdw_p-1:0]          elem_data_i;
    logic                      elem_ready_o;

    logic                      w_en_o;
    logic [addr_width_lp-1:0]  w_addr_o;
    logic [vlen_p*vdw_p-1:0]   w_data_o;

    logic                      busy_o;

    modport slave (
        input  cmd_v_i, cmd_addr_i, elem_v_i, elem_data_i,
        output cmd_ready_o, elem_ready_o, w_en_o, w_addr_o, w_data_o, busy_o
    );

    modport master (
        output cmd_v_i, cmd_addr_i, elem_v_i, elem_data_i,
        input  cmd_ready_o, elem_ready_o, w_en_o, w_addr_o, w_data_o, busy_o
    );
endinterface

// File: rtl/vec_wb_assembler.sv
// rtl/vec_wb_assembler.sv - collects vlen_p result elements into one vector register-file write
//
// Ports:
//   clk_i    sole clock, rising edge
//   reset_i  asynchronous active-high reset
//   bus      vec_wb_assembler_if.slave (command, element stream, write port, busy)
//
// A command latches the destination address; the following vlen_p element
// handshakes fill the buffer in order; the cycle after the last element the
// vector is presented with a single w_en_o strobe. A new command may be
// accepted during that write cycle so vectors can stream without a bubble.

module vec_wb_assembler #(
    parameter int vlen_p  = 8,
    parameter int vdw_p   = 32,
    parameter int els_p   = 32,
    parameter int lanes_p = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    vec_wb_assembler_if.slave     bus
);
    localparam int addr_width_lp = ((els_p / lanes_p) <= 1) ? 1 : $clog2(els_p / lanes_p);
    localparam int cnt_width_lp  = (vlen_p <= 1) ? 1 : $clog2(vlen_p);
    localparam logic [cnt_width_lp-1:0] last_idx_lp = cnt_width_lp'(vlen_p - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2
    } state_e;

    state_e                              state_q, state_d;
    logic [cnt_width_lp-1:0]             cnt_q, cnt_d;
    logic [addr_width_lp-1:0]            addr_q, addr_d;
    logic [vlen_p-1:0][vdw_p-1:0]        buf_q, buf_d;

    logic cmd_ready;
    logic elem_ready;
    logic w_en;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        buf_d      = buf_q;
        cmd_ready  = 1'b0;
        elem_ready = 1'b0;
        w_en       = 1'b0;

        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (bus.cmd_v_i) begin
                    addr_d  = bus.cmd_addr_i;
                    cnt_d   = '0;
                    state_d = COLLECT;
                end
            end

            COLLECT: begin
                // Commands are not accepted here; a stray cmd_v_i simply waits.
                elem_ready = 1'b1;
                if (bus.elem_v_i) begin
                    buf_d[cnt_q] = bus.elem_data_i;
                    if (cnt_q == last_idx_lp) begin
                        cnt_d   = '0;
                        state_d = WRITE;
                    end else begin
                        cnt_d = cnt_q + cnt_width_lp'(1);
                    end
                end
            end

            WRITE: begin
                w_en      = 1'b1;
                cmd_ready = 1'b1;
                // Accepting the next command here overlaps it with the write,
                // so back-to-back vectors see no idle cycle.
                if (bus.cmd_v_i) begin
                    addr_d  = bus.cmd_addr_i;
                    cnt_d   = '0;
                    state_d = COLLECT;
                end else begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode straight from registered state so reset forces them at once.
    assign bus.cmd_ready_o  = cmd_ready;
    assign bus.elem_ready_o = elem_ready;
    assign bus.w_en_o       = w_en;
    assign bus.w_addr_o     = addr_q;
    assign bus.w_data_o     = buf_q;
    assign bus.busy_o       = (state_q != IDLE);

endmodule
